// File: rtl/charmatrix_pkg.sv
// Shared types and constants for the character-matrix stream engine.
package charmatrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_READY,
        ST_WAIT_ACCEPT
    } state_t;

    localparam logic [7:0] CTRL_CLEAR = 8'h0C;
    localparam logic [7:0] CTRL_HOME  = 8'h0D;
    localparam logic [7:0] BLANK_CHAR = 8'h20;

endpackage

// File: rtl/charmatrix_textbuf.sv
// Text/colour slot buffer: decodes control bytes, advances the write pointer,
// and exposes a combinational read port for the frame sequencer.
module charmatrix_textbuf
    import charmatrix_pkg::*;
#(
    parameter int MAX_CHARS = 8,
    parameter int AW        = $clog2(MAX_CHARS),
    parameter int CW        = $clog2(MAX_CHARS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] nc_i,
    input  logic [7:0]    wr_byte_i,
    input  logic          wr_en_i,
    input  logic [3:0]    wr_color_i,
    input  logic [AW-1:0] rd_idx_i,
    output logic [7:0]    rd_char_o,
    output logic [3:0]    rd_color_o
);

    logic [7:0]    slot_q  [MAX_CHARS];
    logic [3:0]    color_q [MAX_CHARS];
    logic [AW-1:0] wr_ptr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q   <= '{default: '0};
            color_q  <= '{default: '0};
            wr_ptr_q <= '0;
        end else if (wr_en_i) begin
            if (wr_byte_i == CTRL_CLEAR) begin
                slot_q   <= '{default: BLANK_CHAR};
                color_q  <= '{default: '0};
                wr_ptr_q <= '0;
            end else if (wr_byte_i == CTRL_HOME) begin
                wr_ptr_q <= '0;
            end else begin
                slot_q[wr_ptr_q]  <= wr_byte_i;
                color_q[wr_ptr_q] <= wr_color_i;
                // Wrap against the live count so a shrunken num_chars still recycles slot 0.
                wr_ptr_q <= (CW'(wr_ptr_q) + CW'(1) >= nc_i) ? '0 : wr_ptr_q + AW'(1);
            end
        end
    end

    assign rd_char_o  = slot_q[rd_idx_i];
    assign rd_color_o = color_q[rd_idx_i];

endmodule

// File: rtl/charmatrix_stream_engine.sv
// Text-matrix stream engine: buffers RX text and streams per-LED GRB words to a WS2812B driver.
// Character scrolling is compiled in only when CHARMATRIX_SCROLL_EN is defined.
module charmatrix_stream_engine
    import charmatrix_pkg::*;
#(
    parameter int  MAX_CHARS   = 8,
    parameter int  GLYPH_W     = 5,
    parameter int  GLYPH_H     = 7,
    parameter int  REFRESH_DIV = 262144,
    parameter int  SCROLL_DIV  = 16,
    localparam int CW          = $clog2(MAX_CHARS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CW-1:0]              num_chars,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    input  logic [3:0]                 rnd_color,
    input  logic                       scroll_en,
    output logic [7:0]                 glyph_addr,
    input  logic [GLYPH_W*GLYPH_H-1:0] glyph_data,
    output logic [3:0]                 color_idx,
    input  logic [23:0]                color_data,
    output logic [23:0]                pix_data,
    output logic                       pix_valid,
    input  logic                       pix_ready,
    output logic                       pix_latch,
    output logic                       busy
);

    localparam int NPIX = GLYPH_W * GLYPH_H;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int AW   = $clog2(MAX_CHARS);
    localparam int RW   = $clog2(REFRESH_DIV);

    state_t        state_q, state_d;
    logic          rdy_q;
    logic          busy_q, busy_d;
    logic          latch_q, latch_d;
    logic          pv_q, pv_d;
    logic [7:0]    gaddr_q, gaddr_d;
    logic [3:0]    cidx_q, cidx_d;
    logic [AW-1:0] char_q, char_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [CW-1:0] ncf_q, ncf_d;
    logic [RW-1:0] ref_q;
    logic          tick, frame_start, frame_end;
    logic [CW-1:0] nc_live, rd_sum;
    logic [AW-1:0] rd_idx, off;
    logic [7:0]    rd_char;
    logic [3:0]    rd_color;

    always_comb begin
        if (num_chars == '0)                   nc_live = CW'(1);
        else if (num_chars > CW'(MAX_CHARS))   nc_live = CW'(MAX_CHARS);
        else                                   nc_live = num_chars;
    end

    // char and offset are both below the latched count, so one conditional subtract is a full modulo.
    assign rd_sum = CW'(char_q) + CW'(off);
    assign rd_idx = AW'((rd_sum >= ncf_q) ? rd_sum - ncf_q : rd_sum);

    charmatrix_textbuf #(
        .MAX_CHARS (MAX_CHARS),
        .AW        (AW),
        .CW        (CW)
    ) u_textbuf (
        .clk        (clk),
        .reset      (reset),
        .nc_i       (nc_live),
        .wr_byte_i  (rx_data),
        .wr_en_i    (rx_valid & rdy_q),
        .wr_color_i (rnd_color),
        .rd_idx_i   (rd_idx),
        .rd_char_o  (rd_char),
        .rd_color_o (rd_color)
    );

    assign tick = (ref_q == RW'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) ref_q <= '0;
        else       ref_q <= tick ? '0 : ref_q + RW'(1);
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        latch_d     = latch_q;
        pv_d        = pv_q;
        gaddr_d     = gaddr_q;
        cidx_d      = cidx_q;
        char_d      = char_q;
        pix_d       = pix_q;
        ncf_d       = ncf_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d     = ST_FETCH;
                    busy_d      = 1'b1;
                    latch_d     = 1'b0;
                    char_d      = '0;
                    pix_d       = '0;
                    ncf_d       = nc_live;
                    frame_start = 1'b1;
                end
            end
            ST_FETCH: begin
                gaddr_d = rd_char;
                cidx_d  = rd_color;
                state_d = ST_WAIT_READY;
            end
            ST_WAIT_READY: begin
                if (pix_ready) begin
                    pv_d    = 1'b1;
                    state_d = ST_WAIT_ACCEPT;
                end
            end
            ST_WAIT_ACCEPT: begin
                if (!pix_ready) begin
                    pv_d = 1'b0;
                    if (pix_q == PW'(NPIX - 1)) begin
                        pix_d = '0;
                        if (CW'(char_q) + CW'(1) == ncf_q) begin
                            state_d   = ST_IDLE;
                            latch_d   = 1'b1;
                            busy_d    = 1'b0;
                            frame_end = 1'b1;
                        end else begin
                            char_d  = char_q + AW'(1);
                            state_d = ST_FETCH;
                        end
                    end else begin
                        pix_d   = pix_q + PW'(1);
                        state_d = ST_WAIT_READY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            latch_q <= 1'b0;
            pv_q    <= 1'b0;
            gaddr_q <= '0;
            cidx_q  <= '0;
            char_q  <= '0;
            pix_q   <= '0;
            ncf_q   <= CW'(1);
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            busy_q  <= busy_d;
            latch_q <= latch_d;
            pv_q    <= pv_d;
            gaddr_q <= gaddr_d;
            cidx_q  <= cidx_d;
            char_q  <= char_d;
            pix_q   <= pix_d;
            ncf_q   <= ncf_d;
        end
    end

`ifdef CHARMATRIX_SCROLL_EN
    localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [AW-1:0] off_q, off_d;
    logic [SW-1:0] fcnt_q, fcnt_d;

    // Offset is re-validated at frame start in case num_chars shrank since the last step.
    always_comb begin
        off_d  = off_q;
        fcnt_d = fcnt_q;
        if (frame_start && (!scroll_en || CW'(off_q) >= nc_live)) begin
            off_d  = '0;
            fcnt_d = '0;
        end else if (frame_end && scroll_en) begin
            if (fcnt_q == SW'(SCROLL_DIV - 1)) begin
                fcnt_d = '0;
                off_d  = (CW'(off_q) + CW'(1) >= ncf_q) ? '0 : off_q + AW'(1);
            end else begin
                fcnt_d = fcnt_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            off_q  <= '0;
            fcnt_q <= '0;
        end else begin
            off_q  <= off_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign off = off_q;
`else
    logic unused_scroll;
    assign off           = '0;
    assign unused_scroll = scroll_en & (SCROLL_DIV > 0) & frame_start & frame_end;
`endif

    assign rx_ready   = rdy_q;
    assign glyph_addr = gaddr_q;
    assign color_idx  = cidx_q;
    assign pix_data   = glyph_data[pix_q] ? color_data : '0;
    assign pix_valid  = pv_q;
    assign pix_latch  = latch_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_charmatrix_stream_engine.sv
// Directed self-checking bench for charmatrix_stream_engine with a glyph/colour ROM and LED driver model.
module tb_charmatrix_stream_engine;

    localparam int MAXC = 8;
    localparam int GW   = 5;
    localparam int GH   = 7;
    localparam int NPIX = GW * GH;
    localparam int RDIV = 2048;
    localparam int SDIV = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    num_chars = 4'd2;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [3:0]    rnd_color = 4'h0;
    logic          scroll_en = 1'b0;
    logic [7:0]    glyph_addr;
    logic [NPIX-1:0] glyph_data;
    logic [3:0]    color_idx;
    logic [23:0]   color_data;
    logic [23:0]   pix_data;
    logic          pix_valid;
    logic          pix_ready = 1'b1;
    logic          pix_latch;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int hold_cycles = 2;
    int low_cycles = 0;
    int valid_while_low = 0;

    logic [7:0]  cap_addr [$];
    logic [23:0] cap_data [$];
    logic [3:0]  cap_cidx [$];

    always #5 clk = ~clk;

    charmatrix_stream_engine #(
        .MAX_CHARS   (MAXC),
        .GLYPH_W     (GW),
        .GLYPH_H     (GH),
        .REFRESH_DIV (RDIV),
        .SCROLL_DIV  (SDIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .num_chars  (num_chars),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rnd_color  (rnd_color),
        .scroll_en  (scroll_en),
        .glyph_addr (glyph_addr),
        .glyph_data (glyph_data),
        .color_idx  (color_idx),
        .color_data (color_data),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_latch  (pix_latch),
        .busy       (busy)
    );

    // Glyph ROM: codes below 0x20 are empty, others light every pixel with (p+code)%3==0.
    function automatic logic gbit(input logic [7:0] a, input int p);
        return (a >= 8'h20) && (((p + int'(a)) % 3) == 0);
    endfunction

    function automatic logic [23:0] crom(input logic [3:0] c);
        return (c == 4'h0) ? 24'h102030 : {4'h0, c, 16'hA55A};
    endfunction

    always_comb begin
        glyph_data = '0;
        for (int p = 0; p < NPIX; p++) glyph_data[p] = gbit(glyph_addr, p);
    end

    assign color_data = crom(color_idx);

    // LED driver: accepts a pixel, drops ready for hold_cycles, flags any valid seen while stalled.
    always @(negedge clk) begin
        if (reset) begin
            pix_ready  = 1'b1;
            low_cycles = 0;
        end else if (pix_ready && pix_valid) begin
            cap_addr.push_back(glyph_addr);
            cap_data.push_back(pix_data);
            cap_cidx.push_back(color_idx);
            pix_ready  = 1'b0;
            low_cycles = 0;
        end else if (!pix_ready) begin
            low_cycles++;
            if (pix_valid) valid_while_low++;
            if (low_cycles >= hold_cycles) pix_ready = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded (got timeout, expected completion)");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic [3:0] c);
        rx_data   = b;
        rnd_color = c;
        rx_valid  = 1'b1;
        @(negedge clk);
        rx_valid  = 1'b0;
    endtask

    task automatic run_frame(output bit ok, output logic latch_at_start);
        int n;
        cap_addr.delete();
        cap_data.delete();
        cap_cidx.delete();
        ok = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 2 * RDIV) begin @(negedge clk); n++; end
        if (busy !== 1'b1) ok = 1'b0;
        latch_at_start = pix_latch;
        n = 0;
        while (busy === 1'b1 && n < 20000) begin @(negedge clk); n++; end
        if (busy === 1'b1) ok = 1'b0;
    endtask

    function automatic int first_bad(input logic [7:0] ch [8], input logic [3:0] co [8],
                                     output logic [7:0] ea, output logic [23:0] ed);
        ea = 8'h00;
        ed = 24'h0;
        for (int i = 0; i < cap_addr.size(); i++) begin
            int c = i / NPIX;
            int p = i % NPIX;
            if (c >= 8) return i;
            ea = ch[c];
            ed = gbit(ch[c], p) ? crom(co[c]) : 24'h0;
            if (cap_addr[i] !== ch[c] || cap_cidx[i] !== co[c] || cap_data[i] !== ed) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_ready, pix_valid, pix_latch, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {rx_ready, pix_valid, pix_latch, busy});
        end
        checks++;
        if ({glyph_addr, color_idx} !== 12'h000) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 000", {glyph_addr, color_idx});
        end
        checks++;
        if (pix_data !== 24'h0) begin
            errors++;
            $display("FAIL reset_pix_data: got %h expected 000000", pix_data);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rx_ready_after_reset: got %b expected 1", rx_ready);
        end
    endtask

    task automatic test_two_chars();
        bit ok;
        logic la;
        logic [7:0] ch [8];
        logic [3:0] co [8];
        logic [7:0] ea;
        logic [23:0] ed;
        int bad;
        num_chars = 4'd2;
        send_byte(8'h41, 4'h3);
        send_byte(8'h42, 4'h5);
        run_frame(ok, la);
        ch = '{8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        co = '{4'h3, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        checks++;
        if (!ok) begin errors++; $display("FAIL two_chars_timeout: got ok=%0d expected 1", ok); end
        checks++;
        if (la !== 1'b0) begin errors++; $display("FAIL latch_at_frame_start: got %b expected 0", la); end
        checks++;
        if (cap_addr.size() !== 70) begin
            errors++;
            $display("FAIL two_chars_count: got %0d expected 70", cap_addr.size());
        end
        checks++;
        if ({cap_addr[0], cap_addr[34], cap_addr[35], cap_addr[69]} !== 32'h41414242) begin
            errors++;
            $display("FAIL two_chars_boundary: got %h %h %h %h expected 41 41 42 42",
                     cap_addr[0], cap_addr[34], cap_addr[35], cap_addr[69]);
        end
        bad = first_bad(ch, co, ea, ed);
        checks++;
        if (bad !== -1) begin
            errors++;
            $display("FAIL two_chars_pixel: idx %0d got addr %h data %h expected addr %h data %h",
                     bad, cap_addr[bad], cap_data[bad], ea, ed);
        end
        checks++;
        if ({pix_latch, busy, pix_valid} !== 3'b100) begin
            errors++;
            $display("FAIL frame_end_flags: got %b expected 100", {pix_latch, busy, pix_valid});
        end
    endtask

    task automatic test_pixel_data();
        bit ok;
        logic la;
        num_chars = 4'd1;
        send_byte(8'h44, 4'h0);
        run_frame(ok, la);
        checks++;
        if (!ok || cap_data.size() !== 35) begin
            errors++;
            $display("FAIL pixel_data_count: got %0d expected 35", cap_data.size());
        end
        checks++;
        if (cap_data[0] !== 24'h000000) begin
            errors++;
            $display("FAIL pix_bit_clear: got %h expected 000000", cap_data[0]);
        end
        checks++;
        if (cap_data[1] !== 24'h102030) begin
            errors++;
            $display("FAIL pix_bit_set: got %h expected 102030", cap_data[1]);
        end
        checks++;
        if (cap_addr[1] !== 8'h44 || cap_cidx[1] !== 4'h0) begin
            errors++;
            $display("FAIL pix_addr: got %h/%h expected 44/0", cap_addr[1], cap_cidx[1]);
        end
    endtask

    task automatic test_wrap_clear();
        bit ok;
        logic la;
        logic [7:0] ch [8];
        logic [3:0] co [8];
        logic [7:0] ea;
        logic [23:0] ed;
        int bad;
        num_chars = 4'd2;
        send_byte(8'h0D, 4'h9);
        send_byte(8'h41, 4'h1);
        send_byte(8'h42, 4'h2);
        send_byte(8'h43, 4'h4);
        run_frame(ok, la);
        ch = '{8'h43, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        co = '{4'h4, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        bad = first_bad(ch, co, ea, ed);
        checks++;
        if (!ok || cap_addr.size() !== 70 || bad !== -1) begin
            errors++;
            $display("FAIL wrap_slots: n=%0d idx %0d got addr %h expected %h",
                     cap_addr.size(), bad, (bad >= 0) ? cap_addr[bad] : 8'h00, ea);
        end
        send_byte(8'h0C, 4'h7);
        run_frame(ok, la);
        ch = '{8'h20, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        co = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        bad = first_bad(ch, co, ea, ed);
        checks++;
        if (!ok || cap_addr.size() !== 70 || bad !== -1) begin
            errors++;
            $display("FAIL clear_slots: n=%0d idx %0d got addr %h expected %h",
                     cap_addr.size(), bad, (bad >= 0) ? cap_addr[bad] : 8'h00, ea);
        end
        send_byte(8'h45, 4'h6);
        run_frame(ok, la);
        ch = '{8'h45, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        co = '{4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        bad = first_bad(ch, co, ea, ed);
        checks++;
        if (!ok || cap_addr.size() !== 70 || bad !== -1) begin
            errors++;
            $display("FAIL clear_wr_ptr: n=%0d idx %0d got addr %h expected %h",
                     cap_addr.size(), bad, (bad >= 0) ? cap_addr[bad] : 8'h00, ea);
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic la;
        logic [7:0] ch [8];
        logic [3:0] co [8];
        logic [7:0] ea;
        logic [23:0] ed;
        int bad;
        num_chars = 4'd1;
        hold_cycles = 50;
        valid_while_low = 0;
        run_frame(ok, la);
        hold_cycles = 2;
        ch = '{8'h45, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        co = '{4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        bad = first_bad(ch, co, ea, ed);
        checks++;
        if (!ok || cap_addr.size() !== 35) begin
            errors++;
            $display("FAIL stall_count: got %0d expected 35", cap_addr.size());
        end
        checks++;
        if (bad !== -1) begin
            errors++;
            $display("FAIL stall_pixel: idx %0d got data %h expected %h", bad, cap_data[bad], ed);
        end
        checks++;
        if (valid_while_low !== 0) begin
            errors++;
            $display("FAIL stall_valid_low: got %0d expected 0", valid_while_low);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        logic la;
        logic [7:0] ch [8];
        logic [3:0] co [8];
        logic [7:0] ea;
        logic [23:0] ed;
        int bad;
        int n = 0;
        num_chars = 4'd2;
        while (pix_valid !== 1'b1 && n < 3 * RDIV) begin @(negedge clk); n++; end
        checks++;
        if (pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL midframe_wait: got pix_valid=%b expected 1", pix_valid);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({rx_ready, pix_valid, pix_latch, busy, glyph_addr, color_idx, pix_data} !== 40'h0) begin
            errors++;
            $display("FAIL midframe_reset: got %b %b %b %b %h %h %h expected all zero",
                     rx_ready, pix_valid, pix_latch, busy, glyph_addr, color_idx, pix_data);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_frame(ok, la);
        ch = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        co = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        bad = first_bad(ch, co, ea, ed);
        checks++;
        if (!ok || cap_addr.size() !== 70 || bad !== -1) begin
            errors++;
            $display("FAIL buffers_zeroed: n=%0d idx %0d got addr %h expected %h",
                     cap_addr.size(), bad, (bad >= 0) ? cap_addr[bad] : 8'h00, ea);
        end
    endtask

    task automatic test_scroll();
        bit ok;
        logic la;
        logic [7:0] base [3];
        logic [3:0] bcol [3];
        logic [7:0] ch [8];
        logic [3:0] co [8];
        logic [7:0] ea;
        logic [23:0] ed;
        logic [7:0] exp_first [7];
        int bad;
        int off;
        num_chars = 4'd3;
        scroll_en = 1'b0;
        send_byte(8'h58, 4'h1);
        send_byte(8'h59, 4'h2);
        send_byte(8'h5A, 4'h3);
        base = '{8'h58, 8'h59, 8'h5A};
        bcol = '{4'h1, 4'h2, 4'h3};
`ifdef CHARMATRIX_SCROLL_EN
        exp_first = '{8'h58, 8'h58, 8'h59, 8'h59, 8'h5A, 8'h5A, 8'h58};
        run_frame(ok, la);
        scroll_en = 1'b1;
`else
        exp_first = '{8'h58, 8'h58, 8'h58, 8'h58, 8'h58, 8'h58, 8'h58};
        scroll_en = 1'b1;
`endif
        for (int f = 0; f < 7; f++) begin
            run_frame(ok, la);
`ifdef CHARMATRIX_SCROLL_EN
            off = (f / SDIV) % 3;
`else
            off = 0;
`endif
            ch = '{default: 8'h00};
            co = '{default: 4'h0};
            for (int c = 0; c < 3; c++) begin
                ch[c] = base[(c + off) % 3];
                co[c] = bcol[(c + off) % 3];
            end
            bad = first_bad(ch, co, ea, ed);
            checks++;
            if (!ok || cap_addr.size() !== 105 || cap_addr[0] !== exp_first[f] || bad !== -1) begin
                errors++;
                $display("FAIL scroll_frame%0d: n=%0d first %h expected %h, bad idx %0d",
                         f + 1, cap_addr.size(), cap_addr[0], exp_first[f], bad);
            end
        end
        scroll_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_two_chars();
        test_pixel_data();
        test_wrap_clear();
        test_stall();
        test_reset_midframe();
        test_scroll();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
